// File: rtl/avalon_burst_ram_pkg.sv
// -----------------------------------------------------------------------------
// avalon_burst_ram_pkg
//
// Shared definitions for the burst-capable Avalon-MM RAM slave:
//   - Avalon bus field widths (address, data, byte-enable, burst count)
//   - FSM state encoding, kept as plain localparam constants so the state
//     register stays a simple logic vector
//   - burst_len(): converts the raw burst-count field into a beat count
// -----------------------------------------------------------------------------
package avalon_burst_ram_pkg;

    // Avalon-MM field widths on the interconnect port.
    localparam int AV_ADDR_W  = 30;
    localparam int AV_DATA_W  = 32;
    localparam int AV_BE_W    = AV_DATA_W / 8;
    localparam int AV_BURST_W = 8;

    // Width of the wait-state counter; the wait parameters are limited to 1..15.
    localparam int WAIT_CNT_W = 4;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_WAIT = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;

    // A burst count of zero is treated as a single-word burst.
    function automatic logic [AV_BURST_W-1:0] burst_len(input logic [AV_BURST_W-1:0] count);
        return (count == '0) ? AV_BURST_W'(1) : count;
    endfunction

endpackage

// File: rtl/avalon_burst_ram_slave_if.sv
// -----------------------------------------------------------------------------
// avalon_burst_ram_slave_if
//
// Avalon-MM slave bus of one interconnect output port.
//   i_AV_Addr        word address / burst base address       (master -> slave)
//   i_AV_ByteEn      byte enables, applied per write beat     (master -> slave)
//   i_AV_Read        read request                             (master -> slave)
//   i_AV_Write       write request or write beat              (master -> slave)
//   i_AV_WriteData   write data                               (master -> slave)
//   i_AV_BurstCount  burst length in words, 0 means 1         (master -> slave)
//   o_AV_ReadData    read data, valid while Read=1, Wait=0    (slave -> master)
//   o_AV_WaitRequest 0 = beat accepted this cycle             (slave -> master)
// The i_/o_ prefixes name the direction as seen from the slave.
// -----------------------------------------------------------------------------
interface avalon_burst_ram_slave_if;
    import avalon_burst_ram_pkg::*;

    logic [AV_ADDR_W-1:0]  i_AV_Addr;
    logic [AV_BE_W-1:0]    i_AV_ByteEn;
    logic                  i_AV_Read;
    logic [AV_DATA_W-1:0]  o_AV_ReadData;
    logic                  i_AV_Write;
    logic [AV_DATA_W-1:0]  i_AV_WriteData;
    logic                  o_AV_WaitRequest;
    logic [AV_BURST_W-1:0] i_AV_BurstCount;

    modport master (
        output i_AV_Addr, i_AV_ByteEn, i_AV_Read, i_AV_Write, i_AV_WriteData, i_AV_BurstCount,
        input  o_AV_ReadData, o_AV_WaitRequest
    );

    modport slave (
        input  i_AV_Addr, i_AV_ByteEn, i_AV_Read, i_AV_Write, i_AV_WriteData, i_AV_BurstCount,
        output o_AV_ReadData, o_AV_WaitRequest
    );

endinterface

// File: rtl/avalon_burst_ram_mem.sv
// -----------------------------------------------------------------------------
// avalon_burst_ram_mem
//
// Byte-enabled register array of 2**MEM_ADDR_BITS 32-bit words.
//   clk      rising-edge clock for the write port
//   wr_en    write strobe; one word written per enabled edge
//   wr_addr  write word address
//   wr_be    per-byte write enables (bit i covers data bits 8i+7..8i)
//   wr_data  write data
//   rd_addr  read word address
//   rd_data  read data, combinational from rd_addr
// -----------------------------------------------------------------------------
module avalon_burst_ram_mem
    import avalon_burst_ram_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [MEM_ADDR_BITS-1:0] wr_addr,
    input  logic [AV_BE_W-1:0]       wr_be,
    input  logic [AV_DATA_W-1:0]     wr_data,
    input  logic [MEM_ADDR_BITS-1:0] rd_addr,
    output logic [AV_DATA_W-1:0]     rd_data
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    logic [AV_DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[rd_addr];

    // NOTE: the array has no reset branch on purpose -- contents survive reset,
    // and a reset loop over every word would turn plain storage into a huge
    // reset tree. Sequential state is always assigned with <= so every flop
    // samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int lane = 0; lane < AV_BE_W; lane++) begin
                if (wr_be[lane]) begin
                    mem[wr_addr][lane*8 +: 8] <= wr_data[lane*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/avalon_burst_ram_slave.sv
// -----------------------------------------------------------------------------
// avalon_burst_ram_slave
//
// Burst-capable on-chip RAM target for one interconnect output port.
// Accepts incrementing read and write bursts of 1..255 words, inserting a
// configurable number of wait-request cycles before the first beat.
//   i_Clk    clock, all logic on the rising edge
//   i_Rst_n  asynchronous active-low reset (memory contents are kept)
//   av       Avalon-MM slave bus (see avalon_burst_ram_slave_if)
// Parameters:
//   MEM_ADDR_BITS          log2 of the memory depth in words; only the low
//                          MEM_ADDR_BITS of the address are decoded here
//   WRITE_WAIT_REQ_CYCLES  wait cycles before the first write beat (1..15)
//   READ_WAIT_REQ_CYCLES   wait cycles before the first read beat (1..15)
// -----------------------------------------------------------------------------
module avalon_burst_ram_slave
    import avalon_burst_ram_pkg::*;
#(
    parameter int MEM_ADDR_BITS         = 8,
    parameter int WRITE_WAIT_REQ_CYCLES = 1,
    parameter int READ_WAIT_REQ_CYCLES  = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_n,
    avalon_burst_ram_slave_if.slave  av
);

    // The wait counter starts at N-1 and the DATA state is entered once it
    // reaches zero; together with the IDLE sampling cycle this gives the
    // master N+1 wait-request cycles before the first beat.
    localparam logic [WAIT_CNT_W-1:0] WR_WAIT_INIT = WAIT_CNT_W'(WRITE_WAIT_REQ_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] RD_WAIT_INIT = WAIT_CNT_W'(READ_WAIT_REQ_CYCLES - 1);

    logic [2:0]               state;
    logic [MEM_ADDR_BITS-1:0] addr;        // address of the next beat
    logic [AV_BURST_W-1:0]    remaining;   // beats still to transfer
    logic [WAIT_CNT_W-1:0]    wait_cnt;
    logic [AV_DATA_W-1:0]     read_data;

    logic [MEM_ADDR_BITS-1:0] cmd_addr;
    logic [MEM_ADDR_BITS-1:0] rd_addr;
    logic [AV_DATA_W-1:0]     mem_rdata;
    logic                     wait_request;
    logic                     wr_beat;
    logic                     rd_beat;
    logic                     last_beat;

    // Upper address bits are decoded by the interconnect, not here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^av.i_AV_Addr[AV_ADDR_W-1:MEM_ADDR_BITS];

    assign cmd_addr  = av.i_AV_Addr[MEM_ADDR_BITS-1:0];
    assign wr_beat   = (state == ST_WR_DATA) && av.i_AV_Write;
    assign rd_beat   = (state == ST_RD_DATA) && av.i_AV_Read;
    assign last_beat = (remaining == AV_BURST_W'(1));

    // Read data is registered one step ahead: the last wait cycle fetches the
    // first word and every accepted read beat fetches the following word, so
    // the data phase streams one word per cycle. Address arithmetic wraps at
    // the top of memory because addr is exactly MEM_ADDR_BITS wide.
    assign rd_addr = (state == ST_RD_DATA) ? addr + MEM_ADDR_BITS'(1) : addr;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        wait_request = 1'b1;
        case (state)
            ST_WR_DATA: wait_request = !av.i_AV_Write;
            ST_RD_DATA: wait_request = !av.i_AV_Read;
            default:    wait_request = 1'b1;
        endcase
    end

    assign av.o_AV_WaitRequest = wait_request;
    assign av.o_AV_ReadData    = read_data;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            read_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Write has priority when both requests arrive together.
                    if (av.i_AV_Write) begin
                        addr      <= cmd_addr;
                        remaining <= burst_len(av.i_AV_BurstCount);
                        wait_cnt  <= WR_WAIT_INIT;
                        state     <= ST_WR_WAIT;
                    end else if (av.i_AV_Read) begin
                        addr      <= cmd_addr;
                        remaining <= burst_len(av.i_AV_BurstCount);
                        wait_cnt  <= RD_WAIT_INIT;
                        state     <= ST_RD_WAIT;
                    end
                end

                ST_WR_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_WR_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end

                ST_RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        read_data <= mem_rdata;
                        state     <= ST_RD_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end

                // Write=0 holds everything: the burst is paused, not aborted.
                ST_WR_DATA: begin
                    if (wr_beat) begin
                        addr      <= addr + MEM_ADDR_BITS'(1);
                        remaining <= remaining - AV_BURST_W'(1);
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                // Read=0 holds read_data and the address until the master resumes.
                ST_RD_DATA: begin
                    if (rd_beat) begin
                        addr      <= addr + MEM_ADDR_BITS'(1);
                        remaining <= remaining - AV_BURST_W'(1);
                        read_data <= mem_rdata;
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    avalon_burst_ram_mem #(
        .MEM_ADDR_BITS (MEM_ADDR_BITS)
    ) u_mem (
        .clk     (i_Clk),
        .wr_en   (wr_beat),
        .wr_addr (addr),
        .wr_be   (av.i_AV_ByteEn),
        .wr_data (av.i_AV_WriteData),
        .rd_addr (rd_addr),
        .rd_data (mem_rdata)
    );

endmodule

// File: tb/tb_avalon_burst_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_avalon_burst_ram_slave
//
// Drives directed and random read/write bursts into avalon_burst_ram_slave.
// A word-array model of the RAM is updated whenever a write beat is accepted;
// read bursts push their expected words into a queue, and a separate monitor
// pops and compares each time the slave presents read data.
// -----------------------------------------------------------------------------
module tb_avalon_burst_ram_slave;

    localparam int MAB   = 8;
    localparam int WR_N  = 1;
    localparam int RD_N  = 2;
    localparam int DEPTH = 1 << MAB;
    localparam int GUARD = 40;

    logic clk;
    logic rst_n;

    avalon_burst_ram_slave_if av();

    avalon_burst_ram_slave #(
        .MEM_ADDR_BITS         (MAB),
        .WRITE_WAIT_REQ_CYCLES (WR_N),
        .READ_WAIT_REQ_CYCLES  (RD_N)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .av      (av)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] wd_q  [$];
    logic [3:0]  be_q  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    endtask

    task automatic fail_now(input string name, input int act, input int req);
        n_total++;
        $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    function automatic int wrap(input logic [29:0] base, input int beat);
        return (int'(base[MAB-1:0]) + beat) % DEPTH;
    endfunction

    function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
        end
    endfunction

    // Monitor: any cycle with Read=1 and WaitRequest=0 is a read beat.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && av.i_AV_Read && !av.i_AV_Write && !av.o_AV_WaitRequest) begin
            if (exp_q.size() == 0) begin
                fail_now("rd_unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", av.o_AV_ReadData, e);
            end
        end
    end

    task automatic write_burst(input logic [29:0] base, input logic [7:0] bc,
                               input int pause_at, input int pause_len, input logic rd_too);
        int n, beat, wcyc, guard;
        n = (bc == 0) ? 1 : int'(bc);
        beat = 0; wcyc = 0; guard = 0;
        av.i_AV_Addr       = base;
        av.i_AV_BurstCount = bc;
        av.i_AV_Write      = 1'b1;
        av.i_AV_Read       = rd_too;
        av.i_AV_WriteData  = wd_q[0];
        av.i_AV_ByteEn     = be_q[0];
        while (beat < n) begin
            @(negedge clk);
            if (!av.o_AV_WaitRequest) begin
                if (beat == 0) check("wr_first_wait", 32'(wcyc), 32'(WR_N + 1));
                model_write(wrap(base, beat), av.i_AV_WriteData, av.i_AV_ByteEn);
                beat++;
                @(posedge clk); #1;
                av.i_AV_Read = 1'b0;
                if (beat < n) begin
                    av.i_AV_Addr       = 30'($urandom);
                    av.i_AV_BurstCount = 8'($urandom);
                    if (beat == pause_at) begin
                        av.i_AV_Write = 1'b0;
                        repeat (pause_len) begin
                            @(negedge clk);
                            check("wr_pause_wait", 32'(av.o_AV_WaitRequest), 32'd1);
                            @(posedge clk); #1;
                        end
                        av.i_AV_Write = 1'b1;
                    end
                    av.i_AV_WriteData = wd_q[beat];
                    av.i_AV_ByteEn    = be_q[beat];
                end
            end else begin
                if (beat == 0) wcyc++;
                guard++;
                if (guard > GUARD) begin
                    fail_now("wr_timeout", guard, GUARD);
                    break;
                end
                @(posedge clk); #1;
                av.i_AV_Read = 1'b0;
            end
        end
        av.i_AV_Write = 1'b0;
        av.i_AV_Read  = 1'b0;
    endtask

    task automatic read_burst(input logic [29:0] base, input logic [7:0] bc,
                              input int pause_at, input int pause_len, input int abort_at);
        int n, beat, rcyc, guard;
        n = (bc == 0) ? 1 : int'(bc);
        beat = 0; rcyc = 0; guard = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(model[wrap(base, i)]);
        av.i_AV_Addr       = base;
        av.i_AV_BurstCount = bc;
        av.i_AV_Read       = 1'b1;
        while (beat < n) begin
            @(negedge clk);
            if (!av.o_AV_WaitRequest) begin
                if (beat == 0) check("rd_first_wait", 32'(rcyc), 32'(RD_N + 1));
                beat++;
                @(posedge clk); #1;
                if (beat == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_wait_req", 32'(av.o_AV_WaitRequest), 32'd1);
                    check("rst_read_data", av.o_AV_ReadData, 32'd0);
                    repeat (n - beat) void'(exp_q.pop_front());
                    av.i_AV_Read = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    break;
                end
                if (beat < n) begin
                    av.i_AV_Addr       = 30'($urandom);
                    av.i_AV_BurstCount = 8'($urandom);
                    if (beat == pause_at) begin
                        av.i_AV_Read = 1'b0;
                        repeat (pause_len) begin
                            @(negedge clk);
                            check("rd_pause_wait", 32'(av.o_AV_WaitRequest), 32'd1);
                            // The next word was already fetched by the last accepted beat.
                            check("rd_pause_hold", av.o_AV_ReadData, model[wrap(base, beat)]);
                            @(posedge clk); #1;
                        end
                        av.i_AV_Read = 1'b1;
                    end
                end
            end else begin
                if (beat == 0) rcyc++;
                guard++;
                if (guard > GUARD) begin
                    fail_now("rd_timeout", guard, GUARD);
                    break;
                end
                @(posedge clk); #1;
            end
        end
        av.i_AV_Read = 1'b0;
    endtask

    task automatic load_random(input int n, input logic rand_be);
        wd_q.delete();
        be_q.delete();
        for (int i = 0; i < n; i++) begin
            wd_q.push_back($urandom);
            be_q.push_back(rand_be ? 4'($urandom) : 4'hF);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, guard;
        logic [7:0] bc;
        rst_n              = 1'b0;
        av.i_AV_Addr       = '0;
        av.i_AV_ByteEn     = '0;
        av.i_AV_Read       = 1'b0;
        av.i_AV_Write      = 1'b0;
        av.i_AV_WriteData  = '0;
        av.i_AV_BurstCount = '0;
        #3;
        check("reset_wait_req", 32'(av.o_AV_WaitRequest), 32'd1);
        check("reset_read_data", av.o_AV_ReadData, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every word a known value so random reads have defined expectations.
        load_random(255, 1'b0);
        write_burst(30'd0, 8'd255, 0, 0, 1'b0);
        load_random(1, 1'b0);
        write_burst(30'd255, 8'd1, 0, 0, 1'b0);

        // Single write then single read.
        wd_q = '{32'hA}; be_q = '{4'hF};
        write_burst(30'h5, 8'd1, 0, 0, 1'b0);
        read_burst(30'h5, 8'd1, 0, 0, 0);

        // Paused write burst, then a consecutive read burst.
        wd_q = '{32'd1, 32'd2, 32'd3, 32'd4}; be_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        write_burst(30'h0, 8'd4, 2, 4, 1'b0);
        read_burst(30'h0, 8'd4, 0, 0, 0);

        // Byte enables and a burst count of zero.
        wd_q = '{32'hFFFF_FFFF}; be_q = '{4'hF};
        write_burst(30'h2, 8'd1, 0, 0, 1'b0);
        wd_q = '{32'h1234_5678, 32'hDEAD_BEEF}; be_q = '{4'b0101, 4'hF};
        write_burst(30'h2, 8'd0, 0, 0, 1'b0);
        read_burst(30'h2, 8'd1, 0, 0, 0);
        check("byte_enable_model", model[2], 32'hFF34_FF78);

        // Wrap at the top of memory; upper address bits are not decoded.
        wd_q = '{32'd7, 32'd8, 32'd9}; be_q = '{4'hF, 4'hF, 4'hF};
        write_burst(30'h3FFF_FFFE, 8'd3, 0, 0, 1'b0);
        read_burst(30'hFE, 8'd3, 0, 0, 0);

        // Read and write asserted together: the write wins.
        load_random(2, 1'b0);
        write_burst(30'h40, 8'd2, 0, 0, 1'b1);
        read_burst(30'h40, 8'd2, 0, 0, 0);

        // Reset in the middle of a read burst, then a fresh single read.
        read_burst(30'h10, 8'd8, 0, 0, 3);
        read_burst(30'h11, 8'd1, 0, 0, 0);

        // Random bursts with pauses, random byte enables and mid-burst noise.
        for (int it = 0; it < 40; it++) begin
            bc = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(10, 40)) : 8'($urandom_range(0, 9));
            n  = (bc == 0) ? 1 : int'(bc);
            if ($urandom_range(0, 1) == 1) begin
                load_random(n, 1'b1);
                write_burst(30'($urandom), bc, $urandom_range(1, n), $urandom_range(1, 3), 1'b0);
            end else begin
                read_burst(30'($urandom), bc, $urandom_range(1, n), $urandom_range(1, 3), 0);
            end
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
